pagerank_iter_engine: RTL

//  Sequential, parametrised PageRank solver. Iterates
//    v'[j] = DN + sum_k adj[j][k]*top(DB*w[k]*v[k])

---
 rtl/pagerank_iter_engine.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pagerank_iter_engine.sv
// Sequential PageRank solver: one edge per cycle through a shared multiplier, double-buffered ranks.
// Optional early exit on convergence when PAGERANK_CONV_EN is defined.
module pagerank_iter_engine #(
   parameter int unsigned      N      = 8,
   parameter int unsigned      WIDTH  = 16,
   parameter int unsigned      ITER_W = 8,
   parameter logic [WIDTH-1:0] DN     = 16'h099A,
   parameter logic [WIDTH-1:0] DB     = 16'hD99A,
   parameter logic [WIDTH-1:0] INIT   = 16'h2000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [N*N-1:0]         adjacency,
   input  logic [N*WIDTH-1:0]     weights,
   input  logic [ITER_W-1:0]      iter_limit,
   input  logic [WIDTH-1:0]       tol,
   output logic                   busy,
   output logic                   done,
   output logic                   converged,
   output logic [ITER_W-1:0]      iter_count,
   input  logic [$clog2(N)-1:0]   rd_addr,
   output logic [WIDTH-1:0]       rd_data
);

   localparam int unsigned IDX_W = $clog2(N);
   localparam int unsigned PW    = 3 * WIDTH;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_SWAP, S_DONE} state_t;

   state_t              state_q, state_d;
   logic                busy_d, done_d;
   logic [N-1:0]        adj_row [N];
   logic [N-1:0]        adj_q   [N];
   logic [WIDTH-1:0]    w_in    [N];
   logic [WIDTH-1:0]    w_q     [N];
   logic [WIDTH-1:0]    v_q     [N];
   logic [WIDTH-1:0]    vn_q    [N];
   logic [ITER_W-1:0]   limit_q;
   logic [IDX_W-1:0]    j_q, k_q;
   logic [WIDTH-1:0]    acc_q, acc_next_c, top_c;
   logic [WIDTH:0]      sum_c;
   logic                start_ok_c, row_end_c, last_edge_c, last_iter_c, conv_hit_c;

   for (genvar g = 0; g < N; g++) begin : g_unpack
      assign adj_row[g] = adjacency[g*N +: N];
      assign w_in[g]    = weights[g*WIDTH +: WIDTH];
   end

   assign start_ok_c  = (state_q == S_IDLE) && start;
   assign row_end_c   = (k_q == IDX_W'(N - 1));
   assign last_edge_c = row_end_c && (j_q == IDX_W'(N - 1));
   assign last_iter_c = ((iter_count + ITER_W'(1)) == limit_q);

   // Edge contribution: top WIDTH bits of DB*w*v, saturating accumulate
   always_comb begin
      top_c      = WIDTH'((PW'(DB) * PW'(w_q[k_q]) * PW'(v_q[k_q])) >> (2 * WIDTH));
      sum_c      = {1'b0, acc_q} + {1'b0, top_c};
      acc_next_c = acc_q;
      if (adj_q[j_q][k_q]) begin
         acc_next_c = sum_c[WIDTH] ? '1 : sum_c[WIDTH-1:0];
      end
   end

`ifdef PAGERANK_CONV_EN
   logic [WIDTH-1:0] tol_q, delta_max_q, delta_c;

   always_comb begin
      delta_c = (acc_next_c >= v_q[j_q]) ? (acc_next_c - v_q[j_q]) : (v_q[j_q] - acc_next_c);
   end

   assign conv_hit_c = (delta_max_q <= tol_q);

   // Largest per-node change seen in the current iteration
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tol_q       <= '0;
         delta_max_q <= '0;
      end else begin
         if (start_ok_c) tol_q <= tol;
         if (state_q == S_LOAD || state_q == S_SWAP) begin
            delta_max_q <= '0;
         end else if (state_q == S_CALC && row_end_c && delta_c > delta_max_q) begin
            delta_max_q <= delta_c;
         end
      end
   end
`else
   logic unused_tol;
   assign unused_tol = ^tol;
   assign conv_hit_c = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD:  state_d = S_CALC;
         S_CALC:  if (last_edge_c) state_d = S_SWAP;
         S_SWAP:  state_d = (conv_hit_c || last_iter_c) ? S_DONE : S_CALC;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_LOAD) || (state_d == S_CALC) || (state_d == S_SWAP);
      done_d = (state_d == S_DONE);
   end

   // Graph latch, row walk, and buffer swap
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         limit_q    <= ITER_W'(1);
         iter_count <= '0;
         converged  <= 1'b0;
         j_q        <= '0;
         k_q        <= '0;
         acc_q      <= DN;
         for (int i = 0; i < N; i++) begin
            adj_q[i] <= '0;
            w_q[i]   <= '0;
            v_q[i]   <= INIT;
            vn_q[i]  <= INIT;
         end
      end else begin
         if (start_ok_c) begin
            limit_q <= (iter_limit == '0) ? ITER_W'(1) : iter_limit;
            for (int i = 0; i < N; i++) begin
               adj_q[i] <= adj_row[i];
               w_q[i]   <= w_in[i];
            end
         end
         case (state_q)
            S_LOAD: begin
               iter_count <= '0;
               converged  <= 1'b0;
               j_q        <= '0;
               k_q        <= '0;
               acc_q      <= DN;
               for (int i = 0; i < N; i++) v_q[i] <= INIT;
            end
            S_CALC: begin
               if (row_end_c) begin
                  vn_q[j_q] <= acc_next_c;
                  acc_q     <= DN;
                  k_q       <= '0;
                  j_q       <= last_edge_c ? '0 : j_q + IDX_W'(1);
               end else begin
                  acc_q <= acc_next_c;
                  k_q   <= k_q + IDX_W'(1);
               end
            end
            S_SWAP: begin
               iter_count <= iter_count + ITER_W'(1);
               converged  <= conv_hit_c;
               for (int i = 0; i < N; i++) v_q[i] <= vn_q[i];
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      if ({1'b0, rd_addr} < (IDX_W + 1)'(N)) rd_data = v_q[rd_addr];
   end

endmodule
